switch_debounce: RTL and testbench
==================================

# switch_debounce

Conditioning stage between the DE10-Lite slide switches and the switch PIO `in_port`. It synchronises each raw switch line into the `clk` domain, applies a per-bit stability filter, and drives a clean level bus for the PIO to read. It also produces single-cycle rise/fall pulses per bit for edge-capture or interrupt logic.

## Interface
- `WIDTH`, 8: number of switch lines.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable `clk` cycles required before a level change is accepted (10 ms at 50 MHz). Legal range is 1 to 2^24−1.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES+1): counter width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_raw`  in  WIDTH  asynchronous switch pins.
- `sw_stable`  out  WIDTH  debounced level; connects to the PIO `in_port`.
- `sw_rise`  out  WIDTH  one-cycle pulse per bit when `sw_stable` goes 0→1.
- `sw_fall`  out  WIDTH  one-cycle pulse per bit when `sw_stable` goes 1→0.
- `sw_changed`  out  1  one-cycle pulse; OR of all `sw_rise` and `sw_fall` bits.

## Operation
- Synchroniser: two flops per bit, `sync1 <= sw_raw`, then `sync2 <= sync1`. No logic between the two stages.
- Each bit runs an independent filter with a `CNT_W`-bit counter `cnt` and the register `sw_stable[i]`.
- **Match** (`sync2[i] == sw_stable[i]`): `cnt <= 0`.
- **Mismatch, `cnt < DEBOUNCE_CYCLES-1`**: `cnt <= cnt + 1`.
- **Mismatch, `cnt == DEBOUNCE_CYCLES-1`**:
  - `sw_stable[i] <= sync2[i]`
  - `cnt <= 0`
  - `sw_rise[i]` or `sw_fall[i]` asserts for exactly the next cycle.
- Glitch rejection: a single matching cycle during a mismatch run clears `cnt`. The run restarts from zero.
- Counter arithmetic is unsigned. `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- `DEBOUNCE_CYCLES == 1`: any mismatch is accepted on the next edge.
- Bits are fully independent. Several bits may update on the same edge. Their pulses assert together and `sw_changed` is a single pulse.
- Pulses are registered outputs: asserted in the same cycle `sw_stable` shows the new value, deasserted one cycle later unless a new acceptance occurs.

## Timing
- Reset values, asynchronous on `reset` high: `sync1`, `sync2`, `sw_stable`, `cnt`, `sw_rise`, `sw_fall` and `sw_changed` all 0.
- Reset deasserting with a switch held high:
  - treated as a normal 0→1 change;
  - `sw_stable` rises `2 + DEBOUNCE_CYCLES` edges after release;
  - `sw_rise` pulses at the same time.
- Latency: a clean `sw_raw` step, sampled at edge k, appears on `sw_stable` after edge `k + 1 + DEBOUNCE_CYCLES`. That is `2 + DEBOUNCE_CYCLES` edges including the sample edge.
- Reset mid-count: counters clear immediately; the level is re-qualified from zero after release.
- Throughput: at most one level change per bit every `DEBOUNCE_CYCLES` cycles.
- No handshake. Outputs are valid every cycle. The PIO adds its own one-cycle read register downstream.

## Structure
- No shared package needed. `CNT_W` is computed locally with `localparam`.
- One sub-module, `switch_debounce_bit`:
  - contains the two-flop synchroniser, counter, stable register and pulse flops for one line;
  - instantiated `WIDTH` times in a generate loop;
  - top level holds only the generate loop and the `sw_changed` OR-reduction.
- Tag the synchroniser flops for CDC timing exclusion on `sw_raw`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `WIDTH=8`.
- **Reset:** assert `reset` with `sw_raw=8'hFF` → all outputs 0 while `reset` is high. Release → `sw_stable=8'hFF` and `sw_rise=8'hFF` for one cycle, exactly 6 edges after release; `sw_changed` pulses once.
- **Clean step:** `sw_raw[0]` 0→1 and held → `sw_stable[0]` rises 6 edges later with a one-cycle `sw_rise[0]`. Release to 0 → `sw_fall[0]` pulses after 6 more edges.
- **Glitch rejection:** `sw_raw[3]` high for 3 cycles then low → `sw_stable` and all pulses stay 0. Bounce pattern 1,1,1,0,1,1,1,1 → exactly one accept, 4 cycles after the last restart.
- **Simultaneous bits:** `sw_raw` 8'h00→8'hA5 on one edge → `sw_stable=8'hA5` and `sw_rise=8'hA5` on the same cycle; `sw_changed` is one pulse.
- **Reset mid-count:** `sw_raw[7]` high, pulse `reset` after 3 cycles of the run → `sw_stable[7]` stays 0 through reset and rises 6 edges after release.
- **`DEBOUNCE_CYCLES=1`:** step `sw_raw[2]` → `sw_stable[2]` updates 3 edges after the step.

Source files
------------

// File: rtl/switch_debounce_bit.sv
// One switch line: two-flop synchroniser, stability counter,
// debounced level register and registered rise/fall pulses.
module switch_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // sw_raw is asynchronous; exclude these two stages from timing
  (* async_reg = "true" *) logic sync1_q;
  (* async_reg = "true" *) logic sync2_q;

  logic             sync1_d;
  logic             sync2_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_d;
  logic             stable_q;
  logic             rise_d;
  logic             rise_q;
  logic             fall_d;
  logic             fall_q;

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bus of slide switches for the switch PIO and
// flags per-bit level changes.
module switch_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .sw_raw   (sw_raw[i]),
      .sw_stable(sw_stable[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i])
    );
  end

  assign sw_changed = |{sw_rise, sw_fall};

endmodule

// File: tb/tb_switch_debounce.sv
// Directed vector bench for switch_debounce at DEBOUNCE_CYCLES=4
// and a second instance at DEBOUNCE_CYCLES=1.
module tb_switch_debounce;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic       chg;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw4 = 8'hFF;
  logic [7:0] raw1 = 8'hFF;
  logic [7:0] st4, ri4, fa4;
  logic [7:0] st1, ri1, fa1;
  logic       ch4, ch1;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .sw_raw(raw4),
    .sw_stable(st4), .sw_rise(ri4), .sw_fall(fa4),
    .sw_changed(ch4)
  );

  switch_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sw_raw(raw1),
    .sw_stable(st1), .sw_rise(ri1), .sw_fall(fa1),
    .sw_changed(ch1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [7:0] st,
                      input logic [7:0] ri, input logic [7:0] fa);
    chk({nm, " stable"}, st4, st);
    chk({nm, " rise"}, ri4, ri);
    chk({nm, " fall"}, fa4, fa);
    chk({nm, " changed"}, {7'd0, ch4}, {7'd0, |{ri, fa}});
  endtask

  function automatic void add(input logic [7:0] r, input logic [7:0] s,
                              input logic [7:0] ri, input logic [7:0] fa);
    vec_t v;
    v.raw = r;
    v.st  = s;
    v.ri  = ri;
    v.fa  = fa;
    v.chg = |{ri, fa};
    tbl.push_back(v);
  endfunction

  function automatic void hold(input logic [7:0] r, input logic [7:0] s,
                               input int n);
    for (int i = 0; i < n; i++) add(r, s, 8'h00, 8'h00);
  endfunction

  initial begin
    int pulses;

    // reset held with all switches high
    tick();
    tick();
    chk4("rst", 8'h00, 8'h00, 8'h00);
    chk("rst dc1 stable", st1, 8'h00);
    chk("rst dc1 changed", {7'd0, ch1}, 8'h00);

    // release: switches high are accepted on the 6th edge
    reset = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (ch4) pulses++;
      if (e == 2) chk("rel dc1 e2", st1, 8'h00);
      if (e == 3) chk("rel dc1 e3", st1, 8'hFF);
      if (e == 3) chk("rel dc1 rise", ri1, 8'hFF);
      if (e == 5) chk4("rel e5", 8'h00, 8'h00, 8'h00);
      if (e == 6) chk4("rel e6", 8'hFF, 8'hFF, 8'h00);
      if (e == 7) chk4("rel e7", 8'hFF, 8'h00, 8'h00);
    end
    chk("rel pulse count", 8'(pulses), 8'd1);

    // return both instances to all-low
    raw4 = 8'h00;
    raw1 = 8'h00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) chk4("drop e6", 8'h00, 8'h00, 8'hFF);
    end
    chk("drop dc1", st1, 8'h00);

    // clean step on bit 0
    hold(8'h01, 8'h00, 5); add(8'h01, 8'h01, 8'h01, 8'h00);
    hold(8'h01, 8'h01, 1);
    hold(8'h00, 8'h01, 5); add(8'h00, 8'h00, 8'h00, 8'h01);
    hold(8'h00, 8'h00, 1);
    // bit 3 high for only 3 cycles
    hold(8'h08, 8'h00, 3); hold(8'h00, 8'h00, 6);
    // bounce 1,1,1,0,1,1,1,1
    hold(8'h08, 8'h00, 3); hold(8'h00, 8'h00, 1);
    hold(8'h08, 8'h00, 5); add(8'h08, 8'h08, 8'h08, 8'h00);
    hold(8'h08, 8'h08, 1);
    hold(8'h00, 8'h08, 5); add(8'h00, 8'h00, 8'h00, 8'h08);
    hold(8'h00, 8'h00, 1);
    // several bits at once, then rise and fall together
    hold(8'hA5, 8'h00, 5); add(8'hA5, 8'hA5, 8'hA5, 8'h00);
    hold(8'hA5, 8'hA5, 1);
    hold(8'h5A, 8'hA5, 5); add(8'h5A, 8'h5A, 8'h5A, 8'hA5);
    hold(8'h5A, 8'h5A, 1);
    hold(8'h00, 8'h5A, 5); add(8'h00, 8'h00, 8'h00, 8'h5A);
    hold(8'h00, 8'h00, 2);

    foreach (tbl[i]) begin
      raw4 = tbl[i].raw;
      tick();
      chk($sformatf("v%0d stable", i), st4, tbl[i].st);
      chk($sformatf("v%0d rise", i), ri4, tbl[i].ri);
      chk($sformatf("v%0d fall", i), fa4, tbl[i].fa);
      chk($sformatf("v%0d changed", i), {7'd0, ch4}, {7'd0, tbl[i].chg});
    end

    // reset one cycle before bit 7 would be accepted
    raw4 = 8'h80;
    for (int e = 1; e <= 5; e++) tick();
    chk4("mid pre", 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    chk4("mid rst", 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    chk4("mid rst hold", 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk4("mid e5", 8'h00, 8'h00, 8'h00);
      if (e == 6) chk4("mid e6", 8'h80, 8'h80, 8'h00);
      if (e == 7) chk4("mid e7", 8'h80, 8'h00, 8'h00);
    end

    // single-cycle qualification
    raw1 = 8'h04;
    tick();
    chk("dc1 e1", st1, 8'h00);
    tick();
    chk("dc1 e2", st1, 8'h00);
    tick();
    chk("dc1 e3 stable", st1, 8'h04);
    chk("dc1 e3 rise", ri1, 8'h04);
    chk("dc1 e3 changed", {7'd0, ch1}, 8'h01);
    tick();
    chk("dc1 e4 rise", ri1, 8'h00);
    raw1 = 8'h00;
    tick();
    tick();
    tick();
    chk("dc1 fall stable", st1, 8'h00);
    chk("dc1 fall", fa1, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
